yuv444_to_422: RTL and testbench

- Output-format stage directly downstream of the down-scale block, in the same pclk domain.
- Consumes the scaler's YUV 4:4:4 href/vsync pixel stream and emits YCbCr 4:2:2: one luma sample plus one alternating chroma sample per cycle.
- Chroma is horizontally averaged over pixel pairs with round-half-up.
- Also reports per-frame geometry (line width, line count) and a sticky odd-width flag for the video DMA/output interface.

---
 rtl/yuv444_to_422_if.sv | 34 +++
 rtl/yuv444_to_422.sv | 190 +++++++++++++++++++
 tb/tb_yuv444_to_422.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/yuv444_to_422_if.sv
// Pixel-stream bundle for the 4:4:4 -> 4:2:2 output stage.
// Holds the scaler-side input stream, the 4:2:2 output stream and the frame-geometry status.
interface yuv444_to_422_if #(
  parameter int BITS  = 8,
  parameter int CNT_W = 12
);
  logic             in_href;
  logic             in_vsync;
  logic [BITS-1:0]  in_y;
  logic [BITS-1:0]  in_u;
  logic [BITS-1:0]  in_v;

  logic             out_href;
  logic             out_vsync;
  logic [BITS-1:0]  out_y;
  logic [BITS-1:0]  out_c;
  logic             out_c_sel;

  logic [CNT_W-1:0] line_width;
  logic [CNT_W-1:0] frame_lines;
  logic             odd_line_err;

  modport master (
    output in_href, in_vsync, in_y, in_u, in_v,
    input  out_href, out_vsync, out_y, out_c, out_c_sel,
    input  line_width, frame_lines, odd_line_err
  );

  modport slave (
    input  in_href, in_vsync, in_y, in_u, in_v,
    output out_href, out_vsync, out_y, out_c, out_c_sel,
    output line_width, frame_lines, odd_line_err
  );
endinterface

// File: rtl/yuv444_to_422.sv
// YUV 4:4:4 to YCbCr 4:2:2 converter: pairwise round-half-up chroma averaging, fixed
// two-cycle latency on href/vsync/data, plus per-frame geometry and odd-width reporting.
module yuv444_to_422 #(
  parameter int BITS  = 8,
  parameter int CNT_W = 12
) (
  input  logic           pclk,
  input  logic           rst_n,
  yuv444_to_422_if.slave vid
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // First delay stage doubles as the "previous" sample for edge detection.
  logic             r_href_d1;
  logic             r_vsync_d1;
  logic             r_phase;
  logic             r_p1_pend;
  logic [BITS-1:0]  r_y0;
  logic [BITS-1:0]  r_u0;
  logic [BITS-1:0]  r_v0;
  logic [BITS-1:0]  r_y1;
  logic [BITS-1:0]  r_cr;

  logic             r_out_href;
  logic             r_out_vsync;
  logic [BITS-1:0]  r_out_y;
  logic [BITS-1:0]  r_out_c;
  logic             r_out_c_sel;

  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W-1:0] r_line_width;
  logic [CNT_W-1:0] r_frame_lines;
  logic             r_odd_err;

  logic             w_line_start;
  logic             w_line_end;
  logic             w_frame_end;
  logic             w_frame_start;
  logic             w_cur_phase;
  logic             w_is_p0;
  logic             w_is_p1;
  logic             w_odd;
  logic             w_count_line;
  logic [CNT_W-1:0] w_line_cnt_inc;

  logic [BITS-1:0]  w_c_held [2];
  logic [BITS-1:0]  w_c_in   [2];
  logic [BITS-1:0]  w_c_avg  [2];

  logic [BITS-1:0]  w_nxt_y;
  logic [BITS-1:0]  w_nxt_c;
  logic             w_nxt_sel;

  assign w_line_start  = vid.in_href & ~r_href_d1;
  assign w_line_end    = r_href_d1 & ~vid.in_href;
  assign w_frame_end   = vid.in_vsync & ~r_vsync_d1;
  assign w_frame_start = r_vsync_d1 & ~vid.in_vsync;

  // The first pixel of every line is a P0 regardless of where the previous line stopped.
  assign w_cur_phase = w_line_start ? 1'b0 : r_phase;
  assign w_is_p0     = vid.in_href & ~w_cur_phase;
  assign w_is_p1     = vid.in_href & w_cur_phase;
  assign w_odd       = w_line_end & r_phase;

  // Index 0 is Cb (U), index 1 is Cr (V).
  assign w_c_held[0] = r_u0;
  assign w_c_held[1] = r_v0;
  assign w_c_in[0]   = vid.in_u;
  assign w_c_in[1]   = vid.in_v;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_avg
      logic [BITS:0] w_sum;
      assign w_sum        = {1'b0, w_c_held[gi]} + {1'b0, w_c_in[gi]} + {{BITS{1'b0}}, 1'b1};
      assign w_c_avg[gi]  = w_sum[BITS:1];
    end
  endgenerate

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_href_d1  <= 1'b0;
      r_vsync_d1 <= 1'b0;
      r_phase    <= 1'b0;
      r_p1_pend  <= 1'b0;
      r_y0       <= '0;
      r_u0       <= '0;
      r_v0       <= '0;
      r_y1       <= '0;
      r_cr       <= '0;
    end else begin
      r_href_d1  <= vid.in_href;
      r_vsync_d1 <= vid.in_vsync;
      if (vid.in_href) begin
        r_phase <= ~w_cur_phase;
      end
      if (w_is_p0) begin
        r_y0 <= vid.in_y;
        r_u0 <= vid.in_u;
        r_v0 <= vid.in_v;
      end
      r_p1_pend <= w_is_p1;
      if (w_is_p1) begin
        r_y1 <= vid.in_y;
        r_cr <= w_c_avg[1];
      end
    end
  end

  // Exactly one source is live per cycle: a pair completing, the Cr half of the
  // previous pair, or an unpaired trailing P0 that keeps its own Cb.
  always_comb begin
    w_nxt_y   = '0;
    w_nxt_c   = '0;
    w_nxt_sel = 1'b0;
    if (w_is_p1) begin
      w_nxt_y = r_y0;
      w_nxt_c = w_c_avg[0];
    end else if (r_p1_pend) begin
      w_nxt_y   = r_y1;
      w_nxt_c   = r_cr;
      w_nxt_sel = 1'b1;
    end else if (w_odd) begin
      w_nxt_y = r_y0;
      w_nxt_c = r_u0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_href  <= 1'b0;
      r_out_vsync <= 1'b0;
      r_out_y     <= '0;
      r_out_c     <= '0;
      r_out_c_sel <= 1'b0;
    end else begin
      r_out_href  <= r_href_d1;
      r_out_vsync <= r_vsync_d1;
      r_out_y     <= w_nxt_y;
      r_out_c     <= w_nxt_c;
      r_out_c_sel <= w_nxt_sel;
    end
  end

  // Lines ending inside vertical blanking are converted but not counted.
  assign w_count_line   = w_line_end & ~r_vsync_d1;
  assign w_line_cnt_inc = (w_count_line && (r_line_cnt != CNT_MAX)) ? r_line_cnt + CNT_ONE
                                                                     : r_line_cnt;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_line_width  <= '0;
      r_frame_lines <= '0;
      r_odd_err     <= 1'b0;
    end else begin
      if (w_line_start) begin
        r_pix_cnt <= CNT_ONE;
      end else if (vid.in_href && (r_pix_cnt != CNT_MAX)) begin
        r_pix_cnt <= r_pix_cnt + CNT_ONE;
      end
      if (w_line_end) begin
        r_line_width <= r_pix_cnt;
      end
      if (w_frame_end) begin
        r_frame_lines <= w_line_cnt_inc;
        r_line_cnt    <= '0;
      end else begin
        r_line_cnt <= w_line_cnt_inc;
      end
      if (w_odd) begin
        r_odd_err <= 1'b1;
      end else if (w_frame_start) begin
        r_odd_err <= 1'b0;
      end
    end
  end

  assign vid.out_href     = r_out_href;
  assign vid.out_vsync    = r_out_vsync;
  assign vid.out_y        = r_out_y;
  assign vid.out_c        = r_out_c;
  assign vid.out_c_sel    = r_out_c_sel;
  assign vid.line_width   = r_line_width;
  assign vid.frame_lines  = r_frame_lines;
  assign vid.odd_line_err = r_odd_err;
endmodule

// File: tb/tb_yuv444_to_422.sv
// Bench for yuv444_to_422: input history drives a per-cycle stream model, with directed
// literal checks on latency, rounding, odd widths, geometry and reset.
module tb_yuv444_to_422;
  localparam int BITS  = 8;
  localparam int CNT_W = 12;
  localparam int HMAX  = 4096;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;

  yuv444_to_422_if #(.BITS(BITS), .CNT_W(CNT_W)) vid ();

  yuv444_to_422 #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .vid   (vid)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;
  int n_edges = 0;

  logic       h_href [HMAX];
  logic       h_vs   [HMAX];
  logic [7:0] h_y    [HMAX];
  logic [7:0] h_u    [HMAX];
  logic [7:0] h_v    [HMAX];

  typedef struct {
    int y;
    int c;
    int sel;
  } out_t;
  out_t cap_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  function automatic logic hh(input int k);
    if (k < 0 || k >= n_edges || k >= HMAX) return 1'b0;
    return h_href[k];
  endfunction

  function automatic logic hv(input int k);
    if (k < 0 || k >= n_edges || k >= HMAX) return 1'b0;
    return h_vs[k];
  endfunction

  // Number of consecutive href-high samples ending at k (1 = first pixel of its line).
  function automatic int run_len(input int k);
    int n;
    n = 0;
    while (hh(k - n)) n++;
    return n;
  endfunction

  // Input history as seen by the design; samples taken in reset count as idle.
  always @(posedge pclk) begin
    if (n_edges < HMAX) begin
      h_href[n_edges] <= rst_n & vid.in_href;
      h_vs[n_edges]   <= rst_n & vid.in_vsync;
      h_y[n_edges]    <= rst_n ? vid.in_y : 8'd0;
      h_u[n_edges]    <= rst_n ? vid.in_u : 8'd0;
      h_v[n_edges]    <= rst_n ? vid.in_v : 8'd0;
    end
    n_edges <= n_edges + 1;
  end

  // Stream model: output now reflects the input sampled two edges ago; a P0 pairs
  // with the following sample, a P1 with the preceding one.
  always @(negedge pclk) begin
    int k;
    int len;
    int ey, ec, es, eh, ev;
    out_t o;
    k  = n_edges - 2;
    eh = 0; ev = 0; ey = 0; ec = 0; es = 0;
    if (rst_n) begin
      eh = int'(hh(k));
      ev = int'(hv(k));
      if (eh != 0) begin
        len = run_len(k);
        ey  = int'(h_y[k]);
        if ((len % 2) == 1) begin
          if (hh(k + 1)) ec = (int'(h_u[k]) + int'(h_u[k + 1]) + 1) / 2;
          else           ec = int'(h_u[k]);
        end else begin
          ec = (int'(h_v[k - 1]) + int'(h_v[k]) + 1) / 2;
          es = 1;
        end
      end
    end
    chk("out_href",  int'(vid.out_href),  eh);
    chk("out_vsync", int'(vid.out_vsync), ev);
    chk("out_y",     int'(vid.out_y),     ey);
    chk("out_c",     int'(vid.out_c),     ec);
    chk("out_c_sel", int'(vid.out_c_sel), es);
    if (rst_n && vid.out_href) begin
      o.y = int'(vid.out_y); o.c = int'(vid.out_c); o.sel = int'(vid.out_c_sel);
      cap_q.push_back(o);
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    vid.in_href = 1'b0;
    vid.in_y = 8'd0; vid.in_u = 8'd0; vid.in_v = 8'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pix(input int y, input int u, input int v);
    vid.in_href = 1'b1;
    vid.in_y = 8'(y); vid.in_u = 8'(u); vid.in_v = 8'(v);
    tick();
  endtask

  task automatic rnd_line(input int n);
    for (int i = 0; i < n; i++)
      pix(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  task automatic vsync_pulse();
    vid.in_vsync = 1'b1;
    tick();
    tick();
    vid.in_vsync = 1'b0;
    tick();
  endtask

  int exp_sel [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};

  initial begin
    vid.in_href = 1'b0; vid.in_vsync = 1'b0;
    vid.in_y = 8'd0; vid.in_u = 8'd0; vid.in_v = 8'd0;

    // Reset held while href toggles
    for (int i = 0; i < 5; i++) begin
      vid.in_href = i[0];
      vid.in_y = 8'd77; vid.in_u = 8'd88; vid.in_v = 8'd99;
      tick();
    end
    chk("rst_out_href", int'(vid.out_href), 0);
    chk("rst_out_y", int'(vid.out_y), 0);
    chk("rst_line_width", int'(vid.line_width), 0);
    chk("rst_frame_lines", int'(vid.frame_lines), 0);
    chk("rst_odd", int'(vid.odd_line_err), 0);
    idle(0);
    rst_n = 1'b1;
    idle(2);

    // Single pair, latency 2
    pix(10, 100, 50);
    chk("lat_href_early", int'(vid.out_href), 0);
    pix(20, 103, 51);
    chk("lat_href", int'(vid.out_href), 1);
    chk("pair_y0", int'(vid.out_y), 10);
    chk("pair_cb", int'(vid.out_c), 102);
    chk("pair_sel0", int'(vid.out_c_sel), 0);
    idle(1);
    chk("pair_y1", int'(vid.out_y), 20);
    chk("pair_cr", int'(vid.out_c), 51);
    chk("pair_sel1", int'(vid.out_c_sel), 1);
    idle(1);
    chk("pair_href_end", int'(vid.out_href), 0);
    idle(2);

    // Rounding and saturation
    cap_q.delete();
    pix(1, 255, 0); pix(2, 255, 1); pix(3, 1, 8); pix(4, 2, 8);
    idle(4);
    chk("rnd_count", cap_q.size(), 4);
    chk("rnd_cb_sat", cap_q[0].c, 255);
    chk("rnd_cr_01", cap_q[1].c, 1);
    chk("rnd_y1", cap_q[1].y, 2);
    chk("rnd_cb_12", cap_q[2].c, 2);
    chk("rnd_cr_88", cap_q[3].c, 8);

    // Odd-width line
    cap_q.delete();
    pix(7, 10, 0); pix(8, 20, 0); pix(9, 30, 0);
    idle(4);
    chk("odd_count", cap_q.size(), 3);
    chk("odd_cb_avg", cap_q[0].c, 15);
    chk("odd_sel1", cap_q[1].sel, 1);
    chk("odd_cb_own", cap_q[2].c, 30);
    chk("odd_sel_last", cap_q[2].sel, 0);
    chk("odd_y_last", cap_q[2].y, 9);
    chk("odd_flag_set", int'(vid.odd_line_err), 1);
    chk("odd_line_width", int'(vid.line_width), 3);
    vid.in_vsync = 1'b1;
    tick();
    tick();
    chk("frame1_lines", int'(vid.frame_lines), 3);
    chk("odd_flag_held", int'(vid.odd_line_err), 1);
    vid.in_vsync = 1'b0;
    tick();
    chk("odd_flag_clear", int'(vid.odd_line_err), 0);
    idle(3);

    // Frame geometry: 4 lines of 8
    for (int l = 0; l < 4; l++) begin
      rnd_line(8);
      idle(3);
    end
    vsync_pulse();
    chk("geo_frame_lines", int'(vid.frame_lines), 4);
    chk("geo_line_width", int'(vid.line_width), 8);
    chk("geo_odd", int'(vid.odd_line_err), 0);
    idle(2);

    // Reset in the middle of line 2
    rnd_line(8);
    idle(2);
    rnd_line(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_width", int'(vid.line_width), 0);
    chk("mid_rst_lines", int'(vid.frame_lines), 0);
    chk("mid_rst_href", int'(vid.out_href), 0);
    idle(3);
    rst_n = 1'b1;
    idle(2);
    for (int l = 0; l < 2; l++) begin
      rnd_line(6);
      idle(2);
    end
    vsync_pulse();
    chk("post_rst_lines", int'(vid.frame_lines), 2);
    chk("post_rst_width", int'(vid.line_width), 6);
    idle(2);

    // Back-to-back lines with 1-cycle gaps, including an odd line
    cap_q.delete();
    rnd_line(4); idle(1);
    rnd_line(4); idle(1);
    rnd_line(3); idle(1);
    rnd_line(2); idle(4);
    chk("b2b_count", cap_q.size(), 13);
    for (int i = 0; i < 13; i++) begin
      if (i < cap_q.size()) chk($sformatf("b2b_sel%0d", i), cap_q[i].sel, exp_sel[i]);
    end
    chk("b2b_odd", int'(vid.odd_line_err), 1);
    chk("b2b_width", int'(vid.line_width), 2);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
